// File: rtl/counter_minimum_if.sv
// counter_minimum_if: control and status bundle of the down counter.
// The master drives enable/load/limit, the slave returns count and wrap.
interface counter_minimum_if #(
  parameter int WIDTH = 4
);
  logic             ena;
  logic             ld;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] cnt;
  logic             wrp;

  modport master (
    output ena,
    output ld,
    output max,
    input  cnt,
    input  wrp
  );

  modport slave (
    input  ena,
    input  ld,
    input  max,
    output cnt,
    output wrp
  );
endinterface

// File: rtl/counter_minimum.sv
// counter_minimum: down counter reloading from a run-time limit.
// Walks max..0 then reloads; wrp is a level high while cnt is zero.
module counter_minimum #(
  parameter int WIDTH          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input logic              clk,
  input logic              rst,
  counter_minimum_if.slave bus
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_next;
  logic             zero;
  logic             do_ld;
  logic             do_rld;
  logic             do_dec;

  assign zero   = (cnt_q == '0);
  assign do_ld  = bus.ld;
  assign do_rld = !bus.ld && bus.ena && zero;
  assign do_dec = !bus.ld && bus.ena && !zero;

  // Next count: load beats enable; zero reloads so no underflow.
  always_comb begin
    cnt_next = cnt_q;
    unique case (1'b1)
      do_ld:   cnt_next = bus.max;
      do_rld:  cnt_next = bus.max;
      do_dec:  cnt_next = cnt_q - WIDTH'(1);
      default: cnt_next = cnt_q;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_next;
  end

  assign bus.cnt = cnt_q;

  if (IMPLEMENTATION == 1) begin : g_reg
    logic wrp_q;

    // Wrap flag precomputed from the next count, so it
    // lines up with cnt without an extra cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) wrp_q <= 1'b1;
      else     wrp_q <= (cnt_next == '0);
    end

    assign bus.wrp = wrp_q;
  end else begin : g_cmb
    assign bus.wrp = zero;
  end

endmodule

// File: tb/tb_counter_minimum.sv
// tb_counter_minimum: both implementations against a behavioural model.
// Model checked every negedge plus literal expectations per scenario.
module tb_counter_minimum;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic         ld  = 1'b0;
  logic [W-1:0] mx  = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int m_cnt  = 0;

  counter_minimum_if #(.WIDTH(W)) b0 ();
  counter_minimum_if #(.WIDTH(W)) b1 ();

  assign b0.ena = ena;
  assign b0.ld  = ld;
  assign b0.max = mx;
  assign b1.ena = ena;
  assign b1.ld  = ld;
  assign b1.max = mx;

  counter_minimum #(.WIDTH(W), .IMPLEMENTATION(0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  counter_minimum #(.WIDTH(W), .IMPLEMENTATION(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: position within a descent of length max+1.
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt = 0;
    else if (ld) m_cnt = int'(mx);
    else if (ena) m_cnt = (m_cnt == 0) ? int'(mx) : m_cnt - 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle compare of both implementations against the model.
  always @(negedge clk) begin
    chk("cnt0_model", int'(b0.cnt), m_cnt);
    chk("cnt1_model", int'(b1.cnt), m_cnt);
    chk("wrp0_model", int'(b0.wrp), (m_cnt == 0) ? 1 : 0);
    chk("wrp1_model", int'(b1.wrp), (m_cnt == 0) ? 1 : 0);
  end

  task automatic step(input logic e, input logic l, input int m);
    ena = e;
    ld  = l;
    mx  = W'(m);
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input int c, input int w);
    chk({nm, "_cnt0"}, int'(b0.cnt), c);
    chk({nm, "_cnt1"}, int'(b1.cnt), c);
    chk({nm, "_wrp0"}, int'(b0.wrp), w);
    chk({nm, "_wrp1"}, int'(b1.wrp), w);
  endtask

  int seq3[10] = '{0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
  int mid[6]   = '{3, 2, 1, 0, 2, 1};

  initial begin
    int en_cnt;
    int guard;
    repeat (2) @(posedge clk);
    #2;
    lit("reset", 0, 1);
    rst = 1'b0;

    // max=3 continuous enable
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 1'b0, 3);
      lit("seq3", seq3[i], (seq3[i] == 0) ? 1 : 0);
    end

    // Finish descent to zero, then max=0 with random enable
    while (b0.cnt != '0) step(1'b1, 1'b0, 3);
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 0);
      lit("max0", 0, 1);
    end

    // Full range with random enable until 18 enabled cycles
    en_cnt = 0;
    guard  = 0;
    while (en_cnt < 18 && guard < 500) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      if (e) en_cnt++;
      guard++;
      step(e, 1'b0, 15);
    end
    chk("full_budget", en_cnt, 18);
    lit("full_end", 14, 0);

    // Load with enable low
    step(1'b0, 1'b1, 5);
    lit("ld5", 5, 0);
    step(1'b1, 1'b0, 5);
    step(1'b1, 1'b0, 5);
    lit("cnt3", 3, 0);
    step(1'b0, 1'b1, 5);
    lit("ld5b", 5, 0);
    step(1'b0, 1'b1, 0);
    lit("ld0", 0, 1);

    // Load while zero and enabled
    step(1'b1, 1'b1, 9);
    lit("ld_zero_ena", 9, 0);

    // Mid-count max change
    step(1'b0, 1'b1, 7);
    lit("ld7", 7, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 7);
    lit("at4", 4, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 2);
      lit("mid", mid[i], (mid[i] == 0) ? 1 : 0);
    end

    // Asynchronous reset at cnt=1, checked before the next edge
    #1 rst = 1'b1;
    #1 lit("async_rst", 0, 1);
    @(posedge clk);
    #2 rst = 1'b0;

    // Random mix of load, enable and limit
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)));

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
